// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing: merges ID/EX stall requests, holds EX through multi-cycle ops,
// applies flush, and counts stalled cycles (saturating).
module pipe_stall_ctrl #(
  parameter int CNT_W  = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              mc_start,
  input  logic [CNT_W-1:0]  mc_cycles,
  input  logic              flush,
  output logic [5:0]        stall,
  output logic              mc_busy,
  output logic              mc_done,
  output logic [PERF_W-1:0] stall_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [5:0]       STALL_EX = 6'b001111;
  localparam logic [5:0]       STALL_ID = 6'b000111;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [PERF_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                ex_hold;
  logic                start_ok;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    ex_hold  = 1'b0;
    mc_done  = 1'b0;
    start_ok = (state_q == IDLE) && mc_start && (mc_cycles > ONE) && !flush;

    if (state_q == IDLE) begin
      if (start_ok) begin
        ex_hold = 1'b1;
        state_d = RUN;
        rem_d   = mc_cycles - ONE;
      end
    end else begin
      // rem counts cycles left including the final (done) cycle
      if (rem_q > ONE) begin
        ex_hold = 1'b1;
        rem_d   = rem_q - ONE;
      end else begin
        mc_done = 1'b1;
        state_d = IDLE;
        rem_d   = '0;
      end
    end

    if (rst || flush) begin
      ex_hold = 1'b0;
      mc_done = 1'b0;
      state_d = IDLE;
      rem_d   = '0;
    end

    stall = 6'b000000;
    if (!rst && !flush) begin
      if (ex_hold || stallreq_ex) begin
        stall = STALL_EX;
      end else if (stallreq_id) begin
        stall = STALL_ID;
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (rst) begin
      stall_cnt_d = '0;
    end else if ((stall != 6'b000000) && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    rem_q       <= rem_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign mc_busy   = (state_q == RUN);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a cycle-indexed op model predicts each cycle's outputs.
module tb_pipe_stall_ctrl;
  localparam int CNT_W  = 5;
  localparam int PERF_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              stallreq_id = 1'b0;
  logic              stallreq_ex = 1'b0;
  logic              mc_start = 1'b0;
  logic [CNT_W-1:0]  mc_cycles = '0;
  logic              flush = 1'b0;
  logic [5:0]        stall;
  logic              mc_busy;
  logic              mc_done;
  logic [PERF_W-1:0] stall_cnt;

  pipe_stall_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .mc_start(mc_start), .mc_cycles(mc_cycles), .flush(flush),
    .stall(stall), .mc_busy(mc_busy), .mc_done(mc_done), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [5:0]        stall;
    logic              busy;
    logic              done;
    logic [PERF_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: an op is a cycle window [op_start, op_end]; EX is held on every cycle but the last.
  bit op_active = 1'b0;
  int op_start  = 0;
  int op_end    = 0;
  int cyc_n     = 0;
  int m_cnt     = 0;

  task automatic drive(input bit r, input bit id, input bit ex, input bit st,
                       input int n, input bit fl);
    exp_t e;
    bit   hold;
    bit   busy;
    @(posedge clk);
    #1;
    rst = r; stallreq_id = id; stallreq_ex = ex; mc_start = st;
    mc_cycles = CNT_W'(n); flush = fl;

    busy = op_active && (cyc_n > op_start);
    if (!op_active && st && (n >= 2) && !r && !fl) begin
      op_active = 1'b1;
      op_start  = cyc_n;
      op_end    = cyc_n + n - 1;
    end
    hold    = op_active && (cyc_n < op_end);
    e.done  = op_active && (cyc_n == op_end) && !r && !fl;
    e.stall = (r || fl) ? 6'h00 : ((hold || ex) ? 6'h0F : (id ? 6'h07 : 6'h00));
    e.busy  = busy;
    e.cnt   = PERF_W'(m_cnt);
    exp_q.push_back(e);

    if (r || fl || (op_active && cyc_n == op_end)) op_active = 1'b0;
    if (r) m_cnt = 0;
    else if (e.stall != 6'h00 && m_cnt < (1 << PERF_W) - 1) m_cnt++;
    cyc_n++;
  endtask

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall",     int'(stall),     int'(e.stall));
      chk("mc_busy",   int'(mc_busy),   int'(e.busy));
      chk("mc_done",   int'(mc_done),   int'(e.done));
      chk("stall_cnt", int'(stall_cnt), int'(e.cnt));
    end
  end

  initial begin
    // reset with active requests
    repeat (3) drive(1, 1, 0, 1, 5, 0);
    drive(0, 0, 0, 0, 0, 0);
    // load-use bubble
    drive(0, 1, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    // 5-cycle op
    drive(0, 0, 0, 1, 5, 0);
    repeat (6) drive(0, 0, 0, 0, 0, 0);
    // trivial ops
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    // 8-cycle op flushed in 3rd RUN cycle, with a competing start
    drive(0, 0, 0, 1, 8, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 5, 1);
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    // stallreq_ex on the done cycle of a 3-cycle op
    drive(0, 0, 0, 1, 3, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    // reset in RUN
    drive(0, 0, 0, 1, 10, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    // priority, then saturation
    drive(0, 1, 1, 0, 0, 0);
    repeat (20) drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int n;
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 10);
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 4) == 0, n, $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
